// File: rtl/bitonic_sort_pkg.sv
// bitonic_sort_pkg: shared lane geometry, FSM states and lane packing helper for bitonic_sort_ctrl
package bitonic_sort_pkg;
  localparam int LANES = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/bitonic_sort_ctrl_lanebuf.sv
// bitonic_sort_ctrl_lanebuf: 8-lane register file with indexed write, pad-fill, parallel load and indexed read
module bitonic_sort_ctrl_lanebuf
  import bitonic_sort_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [IDX_W-1:0]       i_wr_idx,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_pad_en,
  input  logic [CNT_W-1:0]       i_pad_from,
  input  logic                   i_ld_en,
  input  logic [LANES*WIDTH-1:0] i_ld_data,
  input  logic [IDX_W-1:0]       i_rd_idx,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [LANES*WIDTH-1:0] o_lanes
);
  logic [WIDTH-1:0] r_lane [LANES];
  // per lane: sorter load wins, then serial write, then all-ones padding above the last real element
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < LANES; k++) r_lane[k] <= '0;
    else
      for (int k = 0; k < LANES; k++)
        r_lane[k] <= i_ld_en ? i_ld_data[lane_lsb(k, WIDTH) +: WIDTH]
                   : (i_wr_en && i_wr_idx == k[IDX_W-1:0]) ? i_wr_data
                   : (i_pad_en && i_pad_from <= k[CNT_W-1:0]) ? {WIDTH{1'b1}}
                   : r_lane[k];
  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign o_lanes[lane_lsb(g, WIDTH) +: WIDTH] = r_lane[g];
  end
  assign o_rd_data = r_lane[i_rd_idx];
endmodule

// File: rtl/bitonic_sort_ctrl.sv
// bitonic_sort_ctrl: serial valid/ready front/back end for a shared 8-lane sorter; BITONIC_SORT_CTRL_DESC_EN drains in descending order
module bitonic_sort_ctrl
  import bitonic_sort_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SORT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic [LANES*WIDTH-1:0] srt_in,
  input  logic [LANES*WIDTH-1:0] srt_out,
  output logic                   busy
);
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, r_nvalid, w_nvalid_nx, r_wcnt, w_wcnt_nx;
  logic [IDX_W-1:0] r_rdidx, w_rdidx_nx, w_rd_start, w_rd_step;
  logic             r_s_ready, w_s_ready_nx, r_m_valid, w_m_valid_nx;
  logic             w_s_hs, w_m_hs, w_fin, w_last, w_wr_en, w_pad_en, w_ld_en;
  logic [CNT_W-1:0] w_cnt_inc, w_top;
  logic [WIDTH-1:0] w_rd_data;
  assign w_s_hs    = s_valid & r_s_ready;
  assign w_m_hs    = r_m_valid & m_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_top     = r_nvalid - CNT_W'(1);
  assign w_fin     = w_s_hs & (s_last | (w_cnt_inc == CNT_W'(LANES)));
`ifdef BITONIC_SORT_CTRL_DESC_EN
  assign w_last     = r_rdidx == '0;
  assign w_rd_start = w_top[IDX_W-1:0];
  assign w_rd_step  = r_rdidx - IDX_W'(1);
`else
  assign w_last     = {1'b0, r_rdidx} == w_top;
  assign w_rd_start = '0;
  assign w_rd_step  = r_rdidx + IDX_W'(1);
`endif
  // next-state and buffer controls: fill, wait out the sorter latency, drain only the real elements
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_nvalid_nx  = r_nvalid;
    w_wcnt_nx    = r_wcnt;
    w_rdidx_nx   = r_rdidx;
    w_s_ready_nx = r_s_ready;
    w_m_valid_nx = r_m_valid;
    w_wr_en      = 1'b0;
    w_pad_en     = 1'b0;
    w_ld_en      = 1'b0;
    if (r_state == FILL) begin
      w_s_ready_nx = ~w_fin;
      w_wr_en      = w_s_hs;
      w_cnt_nx     = w_s_hs ? w_cnt_inc : r_cnt;
      if (w_fin) begin
        w_pad_en    = 1'b1;
        w_nvalid_nx = w_cnt_inc;
        w_wcnt_nx   = CNT_W'(SORT_LAT);
        w_state_nx  = WAIT;
      end
    end else if (r_state == WAIT) begin
      w_wcnt_nx = r_wcnt - CNT_W'(1);
      if (r_wcnt == '0) begin
        w_wcnt_nx    = r_wcnt;
        w_ld_en      = 1'b1;
        w_rdidx_nx   = w_rd_start;
        w_m_valid_nx = 1'b1;
        w_state_nx   = DRAIN;
      end
    end else if (r_state == DRAIN && w_m_hs) begin
      w_rdidx_nx = w_last ? r_rdidx : w_rd_step;
      if (w_last) begin
        w_m_valid_nx = 1'b0;
        w_s_ready_nx = 1'b1;
        w_cnt_nx     = '0;
        w_state_nx   = FILL;
      end
    end
  end
  // state register; reset discards any partial or in-flight block
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= FILL;
      r_cnt     <= '0;
      r_nvalid  <= '0;
      r_wcnt    <= '0;
      r_rdidx   <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_nvalid  <= w_nvalid_nx;
      r_wcnt    <= w_wcnt_nx;
      r_rdidx   <= w_rdidx_nx;
      r_s_ready <= w_s_ready_nx;
      r_m_valid <= w_m_valid_nx;
    end
  bitonic_sort_ctrl_lanebuf #(.WIDTH(WIDTH)) u_lanebuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_cnt[IDX_W-1:0]),
    .i_wr_data  (s_data),
    .i_pad_en   (w_pad_en),
    .i_pad_from (w_cnt_inc),
    .i_ld_en    (w_ld_en),
    .i_ld_data  (srt_out),
    .i_rd_idx   (r_rdidx),
    .o_rd_data  (w_rd_data),
    .o_lanes    (srt_in)
  );
  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = w_rd_data;
  assign m_last  = (r_state == DRAIN) & w_last;
  assign busy    = (r_state != FILL) | (r_cnt != '0);
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// tb_bitonic_sort_ctrl: directed bench with a queue-based block-sorting model and a registered sorter stand-in
module tb_bitonic_sort_ctrl;
  localparam int W   = 8;
  localparam int LAT = 1;
  logic clk = 1'b0, rst_n = 1'b1;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready, m_valid, m_last, busy;
  logic [W-1:0] m_data;
  logic [8*W-1:0] srt_in, srt_out;
  logic [8*W-1:0] pipe [LAT];
  int total = 0, bad = 0, rdy_mode = 0;
  typedef struct packed {logic [W-1:0] d; logic l;} beat_t;
  beat_t exp_q[$];
  logic [W-1:0] part[$];
  logic [W-1:0] got_d[$];
  logic got_l[$];
  logic held = 1'b0, held_l = 1'b0;
  logic [W-1:0] held_d = '0;

  bitonic_sort_ctrl #(.WIDTH(W), .SORT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .srt_in(srt_in), .srt_out(srt_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8*W-1:0] net_sort(input logic [8*W-1:0] v);
    logic [W-1:0] a[8];
    logic [W-1:0] t;
    logic [8*W-1:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*W +: W];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 8; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= net_sort(srt_in);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign srt_out = pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void close_block();
    logic [W-1:0] s[$];
    s = part;
    s.sort();
`ifdef BITONIC_SORT_CTRL_DESC_EN
    s.reverse();
`endif
    foreach (s[i]) exp_q.push_back('{d: s[i], l: (i == s.size() - 1)});
    part.delete();
  endfunction

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      exp_q.delete();
      part.delete();
      held = 1'b0;
    end else begin
      check("busy", 64'(busy), 64'(part.size() != 0 || exp_q.size() != 0));
      if (held) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(held_d));
        check("hold_last", 64'(m_last), 64'(held_l));
      end
      if (m_valid) check("no_overlap", 64'(s_ready), 64'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(m_valid), 64'd0);
        else begin
          b = exp_q.pop_front();
          check("m_data", 64'(m_data), 64'(b.d));
          check("m_last", 64'(m_last), 64'(b.l));
        end
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      held = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      if (s_valid && s_ready) begin
        part.push_back(s_data);
        if (s_last || part.size() == 8) close_block();
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~m_ready : 1'b0;
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && n < 300) begin @(negedge clk); n++; end
    if (!s_ready) check("send_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin @(negedge clk); n++; end
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_got(input string name, input logic [W-1:0] e[$], input bit fin);
`ifdef BITONIC_SORT_CTRL_DESC_EN
    e.reverse();
`endif
    check({name, "_count"}, 64'(got_d.size() >= e.size()), 64'd1);
    foreach (e[i])
      if (got_d.size() != 0) begin
        check(name, 64'(got_d.pop_front()), 64'(e[i]));
        check({name, "_last"}, 64'(got_l.pop_front()), 64'(i == e.size() - 1));
      end
    if (fin) check({name, "_extra"}, 64'(got_d.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] e[$];
    int n;
    #2 rst_n = 1'b0;
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_srt_in", srt_in, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_s_ready0", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_s_ready1", 64'(s_ready), 64'd1);

    e = '{8'h07, 8'h03, 8'h09, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
    foreach (e[i]) send(e[i], i == 7);
    check("t1_lat_e0", 64'(m_valid), 64'd0);
    check("t1_sready_wait", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    check("t1_lat_e1", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_lat_e2", 64'(m_valid), 64'd1);
    wait_idle("t1");
    e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h08, 8'h09};
    chk_got("t1", e, 1'b1);

    @(posedge clk); #1;
    send(8'h20, 1'b0); send(8'h05, 1'b0); send(8'h10, 1'b1);
    check("t2_pad", srt_in, 64'hFFFF_FFFF_FF10_0520);
    wait_idle("t2");
    check("t2_sready", 64'(s_ready), 64'd1);
    e = '{8'h05, 8'h10, 8'h20};
    chk_got("t2", e, 1'b1);

    @(posedge clk); #1;
    send(8'hFF, 1'b0); send(8'h01, 1'b1);
    wait_idle("t3");
    e = '{8'h01, 8'hFF};
    chk_got("t3", e, 1'b1);

    rdy_mode = 1;
    @(posedge clk); #1;
    e = '{8'h55, 8'h11, 8'hA0, 8'h3C, 8'h00, 8'hC3, 8'h7E, 8'h11,
          8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20};
    foreach (e[i]) send(e[i], 1'b0);
    wait_idle("t4");
    e = '{8'h00, 8'h11, 8'h11, 8'h3C, 8'h55, 8'h7E, 8'hA0, 8'hC3};
    chk_got("t4a", e, 1'b0);
    e = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
    chk_got("t4b", e, 1'b1);

    rdy_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(8'(8'h18 - i), 1'b0);
    n = 0;
    while (!m_valid && n < 50) begin @(negedge clk); n++; end
    check("t5_drain", 64'(m_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_m_valid", 64'(m_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_s_ready", 64'(s_ready), 64'd0);
    check("t5_srt_in", srt_in, 64'd0);
    rdy_mode = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("t5_rel0", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    check("t5_rel1", 64'(s_ready), 64'd1);
    got_d.delete(); got_l.delete();
    send(8'h03, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b1);
    wait_idle("t5");
    e = '{8'h01, 8'h02, 8'h03};
    chk_got("t5", e, 1'b1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
